// File: rtl/requant_pipe_pkg.sv
// Shared types and default widths for the requantizer.
// The top module and the lane module both import this package.
package requant_pipe_pkg;

  localparam int REQ_MULT_W  = 16;
  localparam int REQ_SHIFT_W = 6;

  typedef enum logic [1:0] {
    ACT_NONE = 2'b00,
    ACT_RELU = 2'b01,
    ACT_CLIP = 2'b10
  } act_mode_e;

  typedef struct packed {
    logic signed [REQ_MULT_W-1:0] mult;
    logic        [REQ_SHIFT_W-1:0] shift;
  } requant_cfg_t;

endpackage

// File: rtl/requant_pipe_lane.sv
// One channel of the requantizer datapath: activation and scaling, then rounding shift,
// then zero-point and saturation. Each stage register loads on its own enable from the top.
module requant_lane
  import requant_pipe_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 6,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld1,
  input  logic               ld2,
  input  logic               ld3,
  input  logic [ACC_W-1:0]   acc,
  input  logic [MULT_W-1:0]  mult,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [1:0]         act_mode,
  input  logic [ACC_W-1:0]   clip_max,
  input  logic               round_en,
  input  logic [OUT_W-1:0]   zero_point,
  output logic [OUT_W-1:0]   q,
  output logic               sat
);

  localparam int P = ACC_W + MULT_W;
  localparam logic signed [P:0] MAXV = (P+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [P:0] MINV = -MAXV - 1;

  logic signed [ACC_W-1:0] x, a;
  logic signed [P-1:0]     prod_d, prod_q, shr_d, shr_q;
  logic [SHIFT_W-1:0]      sh1_q;
  logic signed [P:0]       bias, sum, y;
  logic [OUT_W-1:0]        q_d;
  logic                    sat_d;

  // S1: activation and per-channel multiply
  always_comb begin
    x = $signed(acc);
    a = x;
    case (act_mode_e'(act_mode))
      ACT_RELU: if (x < 0) a = '0;
      ACT_CLIP: begin
        if (x < 0) a = '0;
        else if (x > $signed(clip_max)) a = $signed(clip_max);
      end
      default: a = x;
    endcase
    prod_d = $signed({{MULT_W{a[ACC_W-1]}}, a}) * $signed({{ACC_W{mult[MULT_W-1]}}, mult});
  end

  // S2: the sum is one bit wider so the rounding bias can never overflow
  always_comb begin
    bias = '0;
    if (round_en && sh1_q != '0) bias = (P+1)'(1) << (sh1_q - 1'b1);
    sum = {prod_q[P-1], prod_q} + bias;
    if (32'(sh1_q) >= P) shr_d = {P{prod_q[P-1]}};
    else                 shr_d = P'(sum >>> sh1_q);
  end

  // S3: zero-point and clamp
  always_comb begin
    y     = {shr_q[P-1], shr_q} + (P+1)'($signed(zero_point));
    q_d   = y[OUT_W-1:0];
    sat_d = 1'b0;
    if (y > MAXV) begin
      q_d   = MAXV[OUT_W-1:0];
      sat_d = 1'b1;
    end else if (y < MINV) begin
      q_d   = MINV[OUT_W-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      sh1_q  <= '0;
      shr_q  <= '0;
      q      <= '0;
      sat    <= 1'b0;
    end else begin
      if (ld1) begin
        prod_q <= prod_d;
        sh1_q  <= shift;
      end
      if (ld2) shr_q <= shr_d;
      if (ld3) begin
        q   <= q_d;
        sat <= sat_d;
      end
    end
  end

endmodule

// File: rtl/requant_pipe.sv
// NUM_CH-wide requantizer: 3-stage bubble-collapsing valid/ready pipe, per-channel
// mult/shift register file and a saturating count of clamped elements.
module requant_pipe
  import requant_pipe_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int ACC_W   = 32,
  parameter int MULT_W  = REQ_MULT_W,
  parameter int SHIFT_W = REQ_SHIFT_W,
  parameter int OUT_W   = 8,
  parameter int CNT_W   = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*ACC_W-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*OUT_W-1:0] out_data,
  output logic [NUM_CH-1:0]       out_sat,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic [1:0]              act_mode,
  input  logic [ACC_W-1:0]        clip_max,
  input  logic                    round_en,
  input  logic [OUT_W-1:0]        zero_point,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [MULT_W-1:0]       cfg_mult,
  input  logic [SHIFT_W-1:0]      cfg_shift,
  input  logic                    sat_clr,
  output logic [CNT_W-1:0]        sat_count
);

  localparam int PC_W = $clog2(NUM_CH + 1);

  logic v1, v2;
  logic en1, en2, en3;
  logic [NUM_CH-1:0][MULT_W-1:0]  mult_q;
  logic [NUM_CH-1:0][SHIFT_W-1:0] shift_q;
  logic [PC_W-1:0]  pop;
  logic [CNT_W:0]   cnt_sum;

  // A stage may load when empty or when its successor is moving on
  assign en3      = !out_valid || out_ready;
  assign en2      = !v2 || en3;
  assign en1      = !v1 || en2;
  assign in_ready = en1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (en1) v1        <= in_valid;
      if (en2) v2        <= v1;
      if (en3) out_valid <= v2;
    end
  end

  // Lanes read the register file combinationally, so a same-cycle write lands one beat later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mult_q[c]  <= MULT_W'(1);
        shift_q[c] <= '0;
      end
    end else if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
      mult_q[cfg_ch]  <= cfg_mult;
      shift_q[cfg_ch] <= cfg_shift;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    requant_lane #(
      .ACC_W   (ACC_W),
      .MULT_W  (MULT_W),
      .SHIFT_W (SHIFT_W),
      .OUT_W   (OUT_W)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .ld1        (en1 && in_valid),
      .ld2        (en2 && v1),
      .ld3        (en3 && v2),
      .acc        (in_data[c*ACC_W +: ACC_W]),
      .mult       (mult_q[c]),
      .shift      (shift_q[c]),
      .act_mode   (act_mode),
      .clip_max   (clip_max),
      .round_en   (round_en),
      .zero_point (zero_point),
      .q          (out_data[c*OUT_W +: OUT_W]),
      .sat        (out_sat[c])
    );
  end

  always_comb begin
    pop = '0;
    for (int c = 0; c < NUM_CH; c++) pop = pop + PC_W'(out_sat[c]);
    cnt_sum = {1'b0, sat_count} + (CNT_W+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      sat_count <= '0;
    else if (sat_clr)                sat_count <= '0;
    else if (out_valid && out_ready) sat_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_requant_pipe.sv
// Self-checking bench for requant_pipe: vector table plus scoreboard, with hand-written
// sequences for backpressure, counter, config race and mid-stream reset.
module tb_requant_pipe;

  localparam int NUM_CH = 8, ACC_W = 32, MULT_W = 16, SHIFT_W = 6, OUT_W = 8, CNT_W = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH*ACC_W-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_CH*OUT_W-1:0] out_data;
  logic [NUM_CH-1:0]       out_sat;
  logic                    out_valid;
  logic                    out_ready;
  logic [1:0]              act_mode;
  logic [ACC_W-1:0]        clip_max;
  logic                    round_en;
  logic [OUT_W-1:0]        zero_point;
  logic                    cfg_we;
  logic [2:0]              cfg_ch;
  logic [MULT_W-1:0]       cfg_mult;
  logic [SHIFT_W-1:0]      cfg_shift;
  logic                    sat_clr;
  logic [CNT_W-1:0]        sat_count;

  requant_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready),
    .act_mode(act_mode), .clip_max(clip_max), .round_en(round_en), .zero_point(zero_point),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
    .sat_clr(sat_clr), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] act; int clip; bit rnd; int zp; int mult0; int shift0;
    int i0, i1, i2, i3; int e0, e1, e2, e3; logic [7:0] sat;
  } vec_t;

  typedef struct { logic [NUM_CH*OUT_W-1:0] d; logic [NUM_CH-1:0] s; } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0;
  int   seen_beats = 0, ready_low = 0;
  logic [NUM_CH*OUT_W-1:0] prev_d;
  bit   prev_stall = 0;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_CH*ACC_W-1:0] pack_in(int a0, int a1, int a2, int a3, int rest);
    logic [NUM_CH*ACC_W-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c*ACC_W +: ACC_W] = ACC_W'(rest);
    r[0*ACC_W +: ACC_W] = ACC_W'(a0);
    r[1*ACC_W +: ACC_W] = ACC_W'(a1);
    r[2*ACC_W +: ACC_W] = ACC_W'(a2);
    r[3*ACC_W +: ACC_W] = ACC_W'(a3);
    return r;
  endfunction

  function automatic logic [NUM_CH*OUT_W-1:0] pack_out(int e0, int e1, int e2, int e3, int rest);
    logic [NUM_CH*OUT_W-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c*OUT_W +: OUT_W] = OUT_W'(rest);
    r[0*OUT_W +: OUT_W] = OUT_W'(e0);
    r[1*OUT_W +: OUT_W] = OUT_W'(e1);
    r[2*OUT_W +: OUT_W] = OUT_W'(e2);
    r[3*OUT_W +: OUT_W] = OUT_W'(e3);
    return r;
  endfunction

  // Monitor: stall stability, in_ready rule and scoreboard pop
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_d);
      end
      check("in_ready_rule", in_ready, !(sbq.size() == 3 && out_valid && !out_ready));
      if (!in_ready) ready_low <= ready_low + 1;
      if (out_valid && out_ready) begin
        seen_beats <= seen_beats + 1;
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no beat", out_data);
        end else begin
          mon_e = sbq.pop_front();
          check("out_data", out_data, mon_e.d);
          check("out_sat", out_sat, mon_e.s);
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_d     <= out_data;
    end
  end

  task automatic send(logic [NUM_CH*ACC_W-1:0] d, logic [NUM_CH*OUT_W-1:0] ed, logic [NUM_CH-1:0] es);
    bit done = 0;
    in_data  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        sbq.push_back('{ed, es});
        done = 1;
      end
    end
    #1 in_valid = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && sbq.size() != 0; k++) @(posedge clk);
    if (sbq.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(int ch, int m, int s);
    cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_mult = MULT_W'(m); cfg_shift = SHIFT_W'(s);
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic pulse_clr();
    sat_clr = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
  endtask

  vec_t vecs[10];
  bit   pat[6];
  int   base;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd0, 0,  0, 0,   1, 0,  5, -7, 127, -128,  5, -7, 127, -128, 8'h00};
    vecs[1] = '{2'd0, 0,  1, 0,   3, 2,  10, 0, 0, 0,       8, 0, 0, 0,       8'h00};
    vecs[2] = '{2'd0, 0,  0, 0,   3, 2,  10, 0, 0, 0,       7, 0, 0, 0,       8'h00};
    vecs[3] = '{2'd0, 0,  1, 0,   3, 2,  -10, 0, 0, 0,      -7, 0, 0, 0,      8'h00};
    vecs[4] = '{2'd0, 0,  0, 0,   1, 0,  1000, -1000, 0, 0, 127, -128, 0, 0,  8'h03};
    vecs[5] = '{2'd1, 0,  0, 0,   1, 0,  -50, 20, 0, 0,     0, 20, 0, 0,      8'h00};
    vecs[6] = '{2'd2, 60, 0, 0,   1, 0,  100, -5, 60, 61,   60, 0, 60, 60,    8'h00};
    vecs[7] = '{2'd2, 60, 0, -3,  1, 0,  60, 0, -5, 1,      57, -3, -3, -2,   8'h00};
    vecs[8] = '{2'd0, 0,  1, 0,   1, 63, -5, 3, 0, 0,       -1, 3, 0, 0,      8'h00};
    vecs[9] = '{2'd0, 0,  0, 100, 1, 0,  50, -200, 20, 0,   127, -100, 120, 100, 8'h01};
    pat = '{1, 0, 0, 1, 1, 0};

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    act_mode = 2'd0; clip_max = '0; round_en = 1'b0; zero_point = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_mult = '0; cfg_shift = '0; sat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_sat_count", sat_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;

    for (int v = 0; v < 10; v++) begin
      cfg_write(0, vecs[v].mult0, vecs[v].shift0);
      act_mode = vecs[v].act; clip_max = ACC_W'(vecs[v].clip);
      round_en = vecs[v].rnd; zero_point = OUT_W'(vecs[v].zp);
      send(pack_in(vecs[v].i0, vecs[v].i1, vecs[v].i2, vecs[v].i3, 0),
           pack_out(vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3, vecs[v].zp), vecs[v].sat);
      drain();
    end

    // Saturation counter and clear priority
    act_mode = 2'd0; clip_max = '0; round_en = 1'b0; zero_point = '0;
    cfg_write(0, 1, 0);
    pulse_clr();
    check("sat_clr", sat_count, 0);
    send(pack_in(1000, -1000, 0, 0, 0), pack_out(127, -128, 0, 0, 0), 8'h03);
    drain();
    check("sat_count_2", sat_count, 2);
    out_ready = 1'b0;
    send(pack_in(1000, -1000, 0, 0, 0), pack_out(127, -128, 0, 0, 0), 8'h03);
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    check("clr_beat_valid", out_valid, 1);
    @(posedge clk);
    #1 sat_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    @(negedge clk);
    check("sat_clr_priority", sat_count, 0);
    drain();

    // Backpressure stream
    base = seen_beats; ready_low = 0;
    fork
      for (int i = 0; i < 6; i++)
        send(pack_in(i + 1, -(i + 1), 10 * i, 0, 0), pack_out(i + 1, -(i + 1), 10 * i, 0, 0), 8'h00);
      for (int k = 0; k < 40; k++) begin
        out_ready = pat[k % 6];
        @(posedge clk);
        #1;
      end
    join
    out_ready = 1'b1;
    drain();
    check("bp_beat_count", seen_beats - base, 6);
    check("bp_ready_low_seen", ready_low > 0, 1);

    // Config write racing an accept
    in_data = pack_in(4, 0, 0, 0, 0); in_valid = 1'b1;
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_mult = 16'd2; cfg_shift = '0;
    @(negedge clk);
    check("race_ready", in_ready, 1);
    @(posedge clk);
    sbq.push_back('{pack_out(4, 0, 0, 0, 0), 8'h00});
    #1 cfg_we = 1'b0;
    send(pack_in(4, 0, 0, 0, 0), pack_out(8, 0, 0, 0, 0), 8'h00);
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(pack_in(9, 0, 0, 0, 0), pack_out(18, 0, 0, 0, 0), 8'h00);
    send(pack_in(11, 0, 0, 0, 0), pack_out(22, 0, 0, 0, 0), 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    base = seen_beats;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale_beat", seen_beats - base, 0);
    send(pack_in(4, 0, 0, 0, 0), pack_out(4, 0, 0, 0, 0), 8'h00);
    drain();

    // Counter must stick at its maximum
    pulse_clr();
    for (int i = 0; i < 8200; i++)
      send(pack_in(1000, 1000, 1000, 1000, 1000), pack_out(127, 127, 127, 127, 127), 8'hFF);
    drain();
    check("sat_count_max", sat_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
